seg_bus_decoder: RTL and testbench

// Receive end of the multiplexed seven-segment display bus. Samples the

---
 rtl/seg_bus_decoder.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_seg_bus_decoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_bus_decoder.sv
// -----------------------------------------------------------------------------
// seg_bus_decoder
//
// Receive end of a multiplexed seven-segment display bus. The scanned
// active-low segment and anode lines are synchronised, each digit phase is
// qualified by holding still for STABLE_CYCLES synced samples, and the
// qualified segment pattern is decoded back to a hex nibble for the digit
// whose anode is active. Used for display loopback self-test and for reading
// external 7-seg instruments.
//
// Parameters
//   NUM_DIGITS     number of multiplexed digits / anode lines (1..8)
//   STABLE_CYCLES  consecutive identical synced samples required (>= 2)
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   seg_n        in   segments a..g on [0]..[6], active-low, asynchronous
//   an_n         in   anode enables, active-low, asynchronous
//   dp_n         in   decimal point, active-low (SEG_DP_CAPTURE_EN only)
//   err_clr      in   clears pattern_err
//   dp           out  captured decimal point per digit (SEG_DP_CAPTURE_EN only)
//   digits       out  decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  out  digit i holds a decoded hex value
//   frame_done   out  one-cycle pulse once every digit has been captured
//   pattern_err  out  sticky: undecodable pattern or stable multi-anode drive
//
// Build option
//   SEG_DP_CAPTURE_EN  when defined, adds dp_n/dp and captures the decimal
//                      point alongside each digit. Undefined: dp is ignored.
//
// Timing: after the pins change and hold, the capture registers update on
// the (STABLE_CYCLES+2)-th rising edge, counting the first edge that samples
// the new pin values as edge 1.
// -----------------------------------------------------------------------------
module seg_bus_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
`ifdef SEG_DP_CAPTURE_EN
  input  logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dp,
`endif
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    pattern_err
);

  // Layout of the synchronised word: {[dp_n,] an_n, seg_n}
  localparam int AN_LSB = 7;
`ifdef SEG_DP_CAPTURE_EN
  localparam int WORD_W = NUM_DIGITS + 8;
`else
  localparam int WORD_W = NUM_DIGITS + 7;
`endif

  localparam int                    CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_N   = NUM_DIGITS'(1);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;  // no single anode active
  localparam logic [1:0] ST_SETTLE = 2'd1;  // one anode active, waiting for stability
  localparam logic [1:0] ST_HELD   = 2'd2;  // current phase already consumed

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. Resets to all ones, i.e. every line inactive.
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] pin_word;
  logic [WORD_W-1:0] sync1_q;
  logic [WORD_W-1:0] sync2_q;

`ifdef SEG_DP_CAPTURE_EN
  assign pin_word = {dp_n, an_n, seg_n};
`else
  assign pin_word = {an_n, seg_n};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= pin_word;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stability tracking. The change test looks at the word about to enter the
  // second stage, so a change is seen on the same edge that the synced word
  // itself changes; this is what makes capture land on edge STABLE_CYCLES+2.
  // ---------------------------------------------------------------------------
  logic             word_change;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_full;

  assign word_change = (sync1_q != sync2_q);
  assign cnt_d       = word_change        ? '0 :
                       (cnt_q == CNT_MAX) ? cnt_q :
                                            cnt_q + CNT_W'(1);
  assign stable_full = !word_change && (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Anode classification: cur_* is the synced word, next_* the one arriving.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] cur_active;
  logic [NUM_DIGITS-1:0] next_active;
  logic                  cur_one_hot;
  logic                  next_one_hot;
  logic                  cur_multi;

  function automatic logic is_one_hot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - ONE_N)) == '0);
  endfunction

  assign cur_active   = ~sync2_q[AN_LSB +: NUM_DIGITS];
  assign next_active  = ~sync1_q[AN_LSB +: NUM_DIGITS];
  assign cur_one_hot  = is_one_hot(cur_active);
  assign next_one_hot = is_one_hot(next_active);
  // Zero active anodes is inter-digit blanking and never an error.
  assign cur_multi    = (cur_active != '0) && !cur_one_hot;

  // ---------------------------------------------------------------------------
  // Segment decoder on the synced pattern.
  // ---------------------------------------------------------------------------
  logic [3:0] dec_nib;
  logic       dec_hex;
  logic       dec_blank;

  always_comb begin
    dec_nib   = 4'h0;
    dec_hex   = 1'b1;
    dec_blank = 1'b0;
    case (sync2_q[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: begin
        dec_hex   = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_hex = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Phase FSM. A qualified phase produces exactly one event (capture or
  // multi-anode error) and then parks in HELD until the synced word moves.
  // ---------------------------------------------------------------------------
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       capture;
  logic       multi_err;

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    multi_err = 1'b0;
    if (word_change) begin
      state_d = next_one_hot ? ST_SETTLE : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cur_one_hot) begin
            state_d = ST_SETTLE;
          end else if (cur_multi && stable_full) begin
            multi_err = 1'b1;
            state_d   = ST_HELD;
          end
        end
        ST_SETTLE: begin
          if (!cur_one_hot) begin
            state_d = ST_IDLE;
          end else if (stable_full) begin
            capture = 1'b1;
            state_d = ST_HELD;
          end
        end
        ST_HELD: state_d = ST_HELD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit capture registers. During a capture cur_active is one-hot, so
  // it doubles as the write-enable vector.
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [4*NUM_DIGITS-1:0] digits_d;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic [NUM_DIGITS-1:0]   valid_d;
`ifdef SEG_DP_CAPTURE_EN
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   dp_d;
`endif

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic hit;
    assign hit = capture && cur_active[gi];
    // Blank and undecodable patterns keep the previous nibble.
    assign digits_d[4*gi +: 4] = (hit && dec_hex) ? dec_nib : digits_q[4*gi +: 4];
    assign valid_d[gi]         = hit ? dec_hex : valid_q[gi];
`ifdef SEG_DP_CAPTURE_EN
    assign dp_d[gi]            = hit ? ~sync2_q[WORD_W-1] : dp_q[gi];
`endif
  end

  // ---------------------------------------------------------------------------
  // Frame tracking and sticky error.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] mask_q;
  logic [NUM_DIGITS-1:0] mask_d;
  logic                  mask_full;
  logic                  frame_q;
  logic                  err_q;
  logic                  err_d;
  logic                  err_set;

  assign mask_full = &mask_q;
  // A capture on the edge that retires a full mask seeds the next frame.
  assign mask_d    = (mask_full ? '0 : mask_q) | (capture ? cur_active : '0);
  assign err_set   = multi_err || (capture && !dec_hex && !dec_blank);
  // A new error outranks a simultaneous clear.
  assign err_d     = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      valid_q  <= '0;
      mask_q   <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
      dp_q     <= '0;
`endif
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      frame_q  <= mask_full;
      err_q    <= err_d;
`ifdef SEG_DP_CAPTURE_EN
      dp_q     <= dp_d;
`endif
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign pattern_err = err_q;
`ifdef SEG_DP_CAPTURE_EN
  assign dp          = dp_q;
`endif

endmodule

// File: tb/tb_seg_bus_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_bus_decoder
//
// Directed scenarios followed by randomised display scanning. The reference
// model works on the pin level: it measures how many clock edges the pins
// have held one value and fires a capture / error event on the
// (STABLE_CYCLES+2)-th edge of any run that lasted at least STABLE_CYCLES+1
// edges, then applies the decode table and frame/error rules to that event.
// -----------------------------------------------------------------------------
module tb_seg_bus_decoder;

  localparam int N = 4;
  localparam int S = 8;
`ifdef SEG_DP_CAPTURE_EN
  localparam bit USE_DP = 1'b1;
`else
  localparam bit USE_DP = 1'b0;
`endif
  // Synchroniser reset value as seen through the model's 12-bit pin word.
  localparam logic [11:0] SYNC_RST = {USE_DP, 11'h7FF};

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic [N-1:0] an_n;
  logic        dp_n;
  logic        err_clr;
  logic [4*N-1:0] digits;
  logic [N-1:0] digit_valid;
  logic        frame_done;
  logic        pattern_err;
`ifdef SEG_DP_CAPTURE_EN
  logic [N-1:0] dp;
`endif

  always #5 clk = ~clk;

  seg_bus_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
`ifdef SEG_DP_CAPTURE_EN
    .dp_n        (dp_n),
    .dp          (dp),
`endif
    .err_clr     (err_clr),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .pattern_err (pattern_err)
  );

  // Segment codes for hex values 0..F.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_assert = 0;
  int n_fail   = 0;
  int dut_frames = 0;

  // Reference model state
  logic [11:0] m_cur, m_prev;
  int          m_run, m_prev_run;
  logic [N-1:0] m_mask, m_valid, m_dp;
  logic [4*N-1:0] m_digits;
  logic        m_frame, m_err;

  task automatic model_edge();
    logic [11:0] w, evw;
    logic        ev, nerr, full, found;
    logic [N-1:0] act;
    int          idx;
    if (rst) begin
      m_cur = SYNC_RST; m_prev = SYNC_RST;
      m_run = 1000; m_prev_run = 0;
      m_mask = '0; m_valid = '0; m_dp = '0; m_digits = '0;
      m_frame = 1'b0; m_err = 1'b0;
      return;
    end
    w  = {USE_DP ? dp_n : 1'b0, an_n, seg_n};
    ev = 1'b0; evw = '0; nerr = 1'b0;
    if (w == m_cur) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_prev = m_cur; m_prev_run = m_run;
      m_cur = w; m_run = 1;
    end
    if (m_run == S + 2) begin
      ev = 1'b1; evw = m_cur;
    end else if (m_run == 1 && m_prev_run == S + 1) begin
      ev = 1'b1; evw = m_prev;
    end
    full = (m_mask == '1);
    m_frame = full;
    if (full) m_mask = '0;
    if (ev) begin
      act = ~evw[10:7];
      if ($countones(act) == 1) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (act[i]) idx = i;
        m_mask |= act;
        if (USE_DP) m_dp[idx] = ~evw[11];
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
          if (seg_tab[k] == evw[6:0]) begin
            found = 1'b1;
            m_digits[idx*4 +: 4] = 4'(k);
          end
        end
        m_valid[idx] = found;
        if (!found && evw[6:0] != 7'h7F) nerr = 1'b1;
      end else if ($countones(act) > 1) begin
        nerr = 1'b1;
      end
    end
    m_err = nerr ? 1'b1 : (err_clr ? 1'b0 : m_err);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model, then compare all outputs 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (frame_done === 1'b1) dut_frames++;
    n_assert++;
    assert (digits === m_digits) else begin
      n_fail++; $error("FAIL cyc_digits observed=%h expected=%h", digits, m_digits);
    end
    n_assert++;
    assert (digit_valid === m_valid) else begin
      n_fail++; $error("FAIL cyc_valid observed=%b expected=%b", digit_valid, m_valid);
    end
    n_assert++;
    assert (frame_done === m_frame) else begin
      n_fail++; $error("FAIL cyc_frame observed=%b expected=%b", frame_done, m_frame);
    end
    n_assert++;
    assert (pattern_err === m_err) else begin
      n_fail++; $error("FAIL cyc_err observed=%b expected=%b", pattern_err, m_err);
    end
`ifdef SEG_DP_CAPTURE_EN
    n_assert++;
    assert (dp === m_dp) else begin
      n_fail++; $error("FAIL cyc_dp observed=%b expected=%b", dp, m_dp);
    end
`endif
  endtask

  task automatic hold(input logic [N-1:0] a, input logic [6:0] s, input logic d,
                      input int len, input bit rclr);
    an_n = a; seg_n = s; dp_n = d;
    for (int i = 0; i < len; i++) begin
      if (rclr) err_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    if (rclr) err_clr = 1'b0;
    $display("hold an_n=%b seg_n=%h dp_n=%b len=%0d -> digits=%h valid=%b err=%b",
             a, s, d, len, digits, digit_valid, pattern_err);
  endtask

  initial begin
    int frames0, r, len;
    logic [N-1:0] a;
    logic [6:0]   s;

    // Reset state
    rst = 1'b1; an_n = '1; seg_n = 7'h7F; dp_n = 1'b1; err_clr = 1'b0;
    repeat (3) step();
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_valid",  32'(digit_valid), 32'h0);
    check("rst_err",    32'(pattern_err), 32'h0);
    rst = 1'b0;

    // Single digit: capture lands exactly on edge S+2
    an_n = 4'b1110; seg_n = 7'h30;
    repeat (S + 1) step();
    check("t1_valid_early", 32'(digit_valid), 32'h0);
    step();
    check("t1_valid", 32'(digit_valid), 32'h1);
    check("t1_digit0", 32'(digits[3:0]), 32'h3);
    repeat (20 - (S + 2)) step();
    $display("t1 single digit -> digits=%h valid=%b", digits, digit_valid);

    // Four-digit scan
    frames0 = dut_frames;
    hold(4'b1110, 7'h06, 1'b1, 16, 1'b0);
    hold(4'b1101, 7'h0E, 1'b1, 16, 1'b0);
    hold(4'b1011, 7'h08, 1'b1, 16, 1'b0);
    hold(4'b0111, 7'h79, 1'b1, 16, 1'b0);
    check("t2_digits", 32'(digits), 32'h1AFE);
    check("t2_valid",  32'(digit_valid), 32'hF);
    check("t2_frames", 32'(dut_frames - frames0), 32'd1);

    // Blank then undecodable on digit 1, sticky error, clear
    hold(4'b1101, 7'h7F, 1'b1, 16, 1'b0);
    check("t3_blank_valid", 32'(digit_valid), 32'hD);
    check("t3_blank_err",   32'(pattern_err), 32'h0);
    hold(4'b1101, 7'h55, 1'b1, 16, 1'b0);
    check("t3_bad_err", 32'(pattern_err), 32'h1);
    hold(4'b1111, 7'h7F, 1'b1, 6, 1'b0);
    check("t3_sticky", 32'(pattern_err), 32'h1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("t3_cleared", 32'(pattern_err), 32'h0);

    // Glitch every 5 cycles: never qualifies
    for (int i = 0; i < 6; i++) begin
      hold(4'b1011, 7'h24, 1'b1, 4, 1'b0);
      hold(4'b1011, 7'h25, 1'b1, 1, 1'b0);
    end
    hold(4'b1111, 7'h7F, 1'b1, 4, 1'b0);
    check("t4_digits", 32'(digits), 32'h1AFE);
    check("t4_valid",  32'(digit_valid), 32'hD);

    // Two anodes active: error, no update
    hold(4'b1100, 7'h30, 1'b1, 20, 1'b0);
    check("t5_multi_err", 32'(pattern_err), 32'h1);
    check("t5_digits",    32'(digits), 32'h1AFE);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    // Reset mid-scan
    hold(4'b1110, 7'h19, 1'b1, 16, 1'b0);
    hold(4'b1101, 7'h12, 1'b1, 5, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    check("t5_rst_digits", 32'(digits), 32'h0);
    check("t5_rst_valid",  32'(digit_valid), 32'h0);
    check("t5_rst_frame",  32'(frame_done), 32'h0);
    hold(4'b1101, 7'h12, 1'b1, 16, 1'b0);
    check("t5_requal_digits", 32'(digits), 32'h0050);
    check("t5_requal_valid",  32'(digit_valid), 32'h2);

    // Decimal point capture on digit 2
    hold(4'b1011, 7'h40, 1'b0, 16, 1'b0);
`ifdef SEG_DP_CAPTURE_EN
    check("t6_dp", 32'(dp), 32'h4);
`endif
    check("t6_digit2", 32'(digits[11:8]), 32'h0);

    // err_clr held while a bad pattern qualifies: the error wins
    an_n = 4'b1011; seg_n = 7'h55; dp_n = 1'b1; err_clr = 1'b1;
    repeat (S + 2) step();
    err_clr = 1'b0;
    check("t6_err_wins", 32'(pattern_err), 32'h1);
    repeat (4) step();

    // Randomised scanning
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = ~(N'(1) << $urandom_range(0, N - 1));
      else if (r < 8) a = '1;
      else            a = N'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)       s = seg_tab[$urandom_range(0, 15)];
      else if (r == 7) s = 7'h7F;
      else             s = 7'($urandom);
      case ($urandom_range(0, 5))
        0:       len = $urandom_range(1, S - 1);
        1:       len = S;
        2:       len = S + 1;
        3:       len = S + 2;
        default: len = $urandom_range(S + 3, 24);
      endcase
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) step();
        rst = 1'b0;
      end
      hold(a, s, 1'($urandom), len, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
